// File: rtl/aclk_key_entry_if.sv
// Keypad-to-time-register bus for aclk_key_entry.
// The slave side is the entry block; the master side is the keypad/display environment.
interface aclk_key_entry_if;
  logic [3:0] key;
  logic       key_valid;
  logic       one_second;
  logic [3:0] new_ms_hr;
  logic [3:0] new_ls_hr;
  logic [3:0] new_ms_min;
  logic [3:0] new_ls_min;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_new_time;
  logic       key_err;

  modport slave (
    input  key, key_valid, one_second,
    output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
    output load_new_a, load_new_c, show_new_time, key_err
  );

  modport master (
    output key, key_valid, one_second,
    input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
    input  load_new_a, load_new_c, show_new_time, key_err
  );
endinterface

// File: rtl/aclk_key_entry.sv
// Keypad HH:MM entry buffer with validation and one-cycle alarm/time load strobes.
// Optional entry timeout is compiled in with `define ACLK_KEY_TIMEOUT_EN.
module aclk_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input logic             clk,
  input logic             reset,
  aclk_key_entry_if.slave bus
);

  localparam logic [3:0] KeyAlarm = 4'hA;
  localparam logic [3:0] KeyTime  = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;

  typedef enum logic [1:0] {StIdle, StEntry, StLoadA, StLoadC} state_e;

  state_e           state_q, state_d;
  logic [3:0][3:0]  dig_q, dig_d;  // [3]=ms_hr .. [0]=ls_min
  logic [2:0]       count_q, count_d;
  logic             load_a_q, load_a_d;
  logic             load_c_q, load_c_d;
  logic             err_q, err_d;
  logic             show_q, show_d;
  logic             is_digit, is_cmd, time_ok, to_expire;

  assign is_digit = (bus.key <= 4'd9);
  assign is_cmd   = (bus.key == KeyAlarm) || (bus.key == KeyTime);

  assign time_ok = (dig_q[3] <= 4'd2) &&
                   (dig_q[2] <= ((dig_q[3] == 4'd2) ? 4'd3 : 4'd9)) &&
                   (dig_q[1] <= 4'd5) && (dig_q[0] <= 4'd9);

`ifdef ACLK_KEY_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  // Counter only runs in ENTRY; any key in ENTRY wins over a coincident one_second.
  always_comb begin
    to_d      = 8'd0;
    to_expire = 1'b0;
    if (state_q == StEntry && !bus.key_valid) begin
      if (bus.one_second) begin
        if (to_q == 8'(TIMEOUT_SEC - 1)) to_expire = 1'b1;
        else                             to_d = to_q + 8'd1;
      end else begin
        to_d = to_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) to_q <= 8'd0;
    else       to_q <= to_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{bus.one_second, 32'(TIMEOUT_SEC)};
  assign to_expire      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    count_d  = count_q;
    load_a_d = 1'b0;
    load_c_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            dig_d   = {dig_q[2:0], bus.key};
            count_d = 3'd1;
            state_d = StEntry;
          end else if (is_cmd) begin
            err_d = 1'b1;
          end
        end
      end
      StEntry: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            dig_d   = {dig_q[2:0], bus.key};
            count_d = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end else if (bus.key == KeyClear) begin
            dig_d   = '0;
            count_d = 3'd0;
            state_d = StIdle;
          end else if (is_cmd) begin
            if (count_q == 3'd4 && time_ok) begin
              state_d = (bus.key == KeyAlarm) ? StLoadA : StLoadC;
            end else begin
              err_d   = 1'b1;
              dig_d   = '0;
              count_d = 3'd0;
              state_d = StIdle;
            end
          end
        end else if (to_expire) begin
          dig_d   = '0;
          count_d = 3'd0;
          state_d = StIdle;
        end
      end
      // Each load state lasts two cycles: arm the strobe, then retire it and clear.
      StLoadA: begin
        if (load_a_q) begin
          dig_d   = '0;
          count_d = 3'd0;
          state_d = StIdle;
        end else begin
          load_a_d = 1'b1;
        end
      end
      StLoadC: begin
        if (load_c_q) begin
          dig_d   = '0;
          count_d = 3'd0;
          state_d = StIdle;
        end else begin
          load_c_d = 1'b1;
        end
      end
    endcase
    show_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      dig_q    <= '0;
      count_q  <= 3'd0;
      load_a_q <= 1'b0;
      load_c_q <= 1'b0;
      err_q    <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      count_q  <= count_d;
      load_a_q <= load_a_d;
      load_c_q <= load_c_d;
      err_q    <= err_d;
      show_q   <= show_d;
    end
  end

  assign bus.new_ms_hr     = dig_q[3];
  assign bus.new_ls_hr     = dig_q[2];
  assign bus.new_ms_min    = dig_q[1];
  assign bus.new_ls_min    = dig_q[0];
  assign bus.load_new_a    = load_a_q;
  assign bus.load_new_c    = load_c_q;
  assign bus.show_new_time = show_q;
  assign bus.key_err       = err_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Self-checking bench for aclk_key_entry: directed plan steps plus random keys vs. a digit-list model.
module tb_aclk_key_entry;

  localparam int unsigned TimeoutSec = 3;
`ifdef ACLK_KEY_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk;
  logic reset;
  aclk_key_entry_if bus ();

  aclk_key_entry #(.TIMEOUT_SEC(TimeoutSec)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model: the last four entered digits as numbers, plus entry/load bookkeeping.
  int md[4];      // md[0]=ms_hr .. md[3]=ls_min
  int mcnt, mto, mld;
  bit mentry, mld_c, merr, mla, mlc;

  function automatic bit time_ok();
    int hh, mm;
    hh = md[0] * 10 + md[1];
    mm = md[2] * 10 + md[3];
    return (hh < 24) && (mm < 60);
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcnt = 0; mto = 0; mld = 0; mentry = 1'b0;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic step(input int k, input bit v, input bit s, input bit r);
    bus.key        = 4'(k);
    bus.key_valid  = v;
    bus.one_second = s;
    reset          = r;
    @(posedge clk);
    cycle++;
    merr = 1'b0; mla = 1'b0; mlc = 1'b0;
    if (r) begin
      clear_all();
    end else if (mld == 1) begin
      mld = 2;
      if (mld_c) mlc = 1'b1; else mla = 1'b1;
    end else if (mld == 2) begin
      clear_all();
    end else if (v) begin
      mto = 0;
      if (k <= 9) begin
        md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = k;
        if (mcnt < 4) mcnt++;
        mentry = 1'b1;
      end else if (k == 10 || k == 11) begin
        if (!mentry) merr = 1'b1;
        else if (mcnt == 4 && time_ok()) begin
          mld = 1;
          mld_c = (k == 11);
        end else begin
          merr = 1'b1;
          clear_all();
        end
      end else if (k == 12) begin
        clear_all();
      end
    end else if (s && mentry && ToEn) begin
      mto++;
      if (mto == int'(TimeoutSec)) clear_all();
    end
    #1;
    bus.key_valid  = 1'b0;
    bus.one_second = 1'b0;
    reset          = 1'b0;
    check("ms_hr",  bus.new_ms_hr,  4'(md[0]));
    check("ls_hr",  bus.new_ls_hr,  4'(md[1]));
    check("ms_min", bus.new_ms_min, 4'(md[2]));
    check("ls_min", bus.new_ls_min, 4'(md[3]));
    check("load_new_a",    {3'b0, bus.load_new_a},    {3'b0, mla});
    check("load_new_c",    {3'b0, bus.load_new_c},    {3'b0, mlc});
    check("show_new_time", {3'b0, bus.show_new_time}, {3'b0, mentry});
    check("key_err",       {3'b0, bus.key_err},       {3'b0, merr});
    check("strobe_excl",   {3'b0, bus.load_new_a & bus.load_new_c}, 4'd0);
  endtask

  task automatic press(input int k);
    step(k, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sec();
    step(0, 1'b0, 1'b1, 1'b0);
  endtask

  int r, k;

  initial begin
    bus.key = 4'd0; bus.key_valid = 1'b0; bus.one_second = 1'b0; reset = 1'b1;
    clear_all();
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // 07:30 alarm load
    press(0); press(7); press(3); press(0); press(10); idle(3);
    // more than four digits, keep the last four, time load
    press(1); press(2); press(0); press(0); press(0); press(5); press(11); idle(3);
    // invalid values and a valid 23:59
    press(2); press(4); press(0); press(0); press(10); idle(2);
    press(1); press(2); press(6); press(0); press(11); idle(2);
    press(2); press(3); press(5); press(9); press(11); idle(3);
    // short entry, clear, command in idle, ignored codes
    press(1); press(2); press(10); idle(1);
    press(1); press(12); idle(1);
    press(10); idle(1);
    press(13); press(15); press(12); idle(1);

    // timeout behaviour (abandon when compiled in, persist otherwise)
    press(5); sec(); sec(); sec(); idle(1);
    press(5); sec(); sec(); step(6, 1'b1, 1'b1, 1'b0); sec(); sec(); sec(); idle(1);
    press(12);
    press(5); for (int i = 0; i < 20; i++) sec();
    press(12); idle(1);

    // reset right after ALARM kills the strobe; keys during load are dropped
    press(0); press(8); press(1); press(5); press(10);
    step(0, 1'b0, 1'b0, 1'b1); idle(3);
    press(0); press(8); press(1); press(5); press(10); press(3); press(4); idle(2);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = int'($urandom_range(0, 9));
      else if (r < 67) k = 10;
      else if (r < 79) k = 11;
      else if (r < 87) k = 12;
      else             k = int'($urandom_range(13, 15));
      step(k, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
